mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Load/store unit directly upstream of the byte-masked word memory (1024 x 32, 1-cycle registered read, per-byte write mask, word-indexed address).
- Accepts byte-addressed, sized load/store requests from the CPU. Converts them to word address, byte write mask and lane-replicated write data.
- Returns aligned, sign- or zero-extended load data through a valid/ready response channel.
- Reports misaligned, out-of-range or illegal-size requests as errors without touching memory.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the downstream memory; word index >= MEM_WORDS is out of range.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request (high only in IDLE).
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned_i  in  1  loads only: zero-extend instead of sign-extend.
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data, right-justified.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_rdata_o  out  32  load result; 0 for stores and errors.
- rsp_err_o  out  1  request rejected.
- mem_addr_o  out  32  word index {2'b0, addr[31:2]} to the memory.
- mem_we_o  out  1  memory write enable.
- mem_wr_mask_o  out  4  byte-lane write mask.
- mem_data_o  out  32  lane-replicated write data.
- mem_data_i  in  32  memory read data, valid one cycle after mem_addr_o is presented.

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready_o = 1. Reset mid-transaction drops the transaction; no response is produced and mem_we_o is 0 from the next cycle.
- States: IDLE, ACCESS, WAIT, RESP. All mem_* and rsp_* outputs are registered.
- IDLE: on req_valid_i & req_ready_o (cycle T), latch the request and check it.
  - Illegal if size = 3, if half and addr[0] = 1, if word and addr[1:0] != 0, or if addr[31:2] >= MEM_WORDS.
  - Illegal request: go to RESP with rsp_err_o = 1 and rsp_rdata_o = 0. rsp_valid_o is high at T+1.
  - Legal request: go to ACCESS.
- ACCESS (T+1): mem_addr_o is driven. For a store, mem_we_o = 1 with mask and data, the memory commits at the end of T+1, and the next state is RESP (rsp_valid_o at T+2). For a load, mem_we_o = 0 and the next state is WAIT.
- WAIT (T+2): mem_addr_o is held. Extract the lane from mem_data_i, extend it, and register it into rsp_rdata_o. Next state is RESP, so load rsp_valid_o is at T+3.
- RESP: rsp_valid_o is held high, with data stable, until rsp_ready_i. On the handshake cycle, rsp_valid_o drops and the unit returns to IDLE. req_ready_o rises the next cycle; back-to-back requests are not overlapped.
- Outside ACCESS: mem_we_o = 0 and mem_wr_mask_o = 0.
- Write lanes:
  - Byte: mask = 4'b0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - Half: mask = 4'b0011 << {addr[1],1'b0}; data = {2{wdata[15:0]}}.
  - Word: mask = 4'b1111; data = wdata.
- Load extract:
  - Byte: mem_data_i[8*addr[1:0] +: 8].
  - Half: mem_data_i[16*addr[1] +: 16].
  - Word: mem_data_i unchanged.
  - Sign-extend from bit 7 or 15 unless req_unsigned_i; req_unsigned_i is ignored for words.
- Inputs on req_* are ignored outside IDLE.

Decomposition:
- Package lsu_pkg:
  - size_t enum (SZ_BYTE, SZ_HALF, SZ_WORD).
  - state_t enum (IDLE, ACCESS, WAIT, RESP).
  - Function misaligned(size, addr[1:0]).
- Sub-module lsu_align (combinational): size, addr[1:0] and wdata produce mask and lane data; size, unsigned, addr[1:0] and rdata produce the extended result. Reused by the top for both directions.

Test Plan:
- Store byte 0xA5 at addr 0x0000_0006 -> at T+1 mem_addr_o = 1, mask = 4'b0100, mem_data_o = 0xA5A5A5A5; rsp_valid_o at T+2 with err = 0.
- After word 0x8081_7F01 is stored at addr 0x10:
  - signed byte load at 0x13 -> rsp_rdata_o = 0xFFFF_FF80 at T+3.
  - unsigned half load at 0x12 -> 0x0000_8081.
  - signed half load at 0x10 -> 0x0000_7F01.
- Word load at 0x0000_0002 -> rsp_err_o = 1 at T+1, rdata = 0, mem_we_o never asserted. Same result for half at 0x1 and size = 3.
- Word store at 0x0000_1000 (word 1024, MEM_WORDS = 1024) -> rsp_err_o = 1, no write. Word at 0x0FFC -> accepted.
- Hold rsp_ready_i = 0 for 5 cycles after a load -> rsp_valid_o and rsp_rdata_o stable, req_ready_o = 0. Release -> IDLE the next cycle; a new request is accepted.
- Assert reset_i during WAIT -> next cycle IDLE, rsp_valid_o = 0, req_ready_o = 1, no response ever issued for the dropped load.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned MEM_WORDS_DEF = 1024;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Size code 3 has no access width, so it is treated as misaligned too.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/replication and load extract/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  mask_o,
    output logic [31:0] lane_data_o,
    output logic [31:0] ext_data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Decode lane mask, replicate store data and extend the selected load lane.
    always_comb begin
        mask_o      = 4'b0000;
        lane_data_o = 32'h0;
        ext_data_o  = 32'h0;
        byte_lane   = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_lane   = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: begin
                mask_o      = 4'b0001 << addr_lo_i;
                lane_data_o = {4{wdata_i[7:0]}};
                ext_data_o  = unsigned_i ? {24'h0, byte_lane}
                                         : {{24{byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                mask_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
                lane_data_o = {2{wdata_i[15:0]}};
                ext_data_o  = unsigned_i ? {16'h0, half_lane}
                                         : {{16{half_lane[15]}}, half_lane};
            end
            SZ_WORD: begin
                mask_o      = 4'b1111;
                lane_data_o = wdata_i;
                ext_data_o  = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a byte-masked, 1-cycle-read word memory.
//
// state  | meaning
// IDLE   | ready for a request; checks and latches it on handshake
// ACCESS | address (and store mask/data) presented to memory
// WAIT   | load data returns; lane extracted and extended
// RESP   | response held until the consumer takes it
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_wr_mask_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_mask_q, mem_mask_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        idle;
    logic        req_bad;
    logic [3:0]  al_mask;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    assign idle = (state_q == IDLE);

    // One aligner serves both directions: the store path only needs it in IDLE
    // (live request fields), the load path only in WAIT (latched fields).
    lsu_align u_align (
        .size_i      (idle ? req_size_i : size_q),
        .addr_lo_i   (idle ? req_addr_i[1:0] : addr_lo_q),
        .unsigned_i  (uns_q),
        .wdata_i     (req_wdata_i),
        .rdata_i     (mem_data_i),
        .mask_o      (al_mask),
        .lane_data_o (al_wdata),
        .ext_data_o  (al_rdata)
    );

    // Request legality: bad size/alignment or word index past the memory.
    always_comb begin
        req_bad = misaligned(req_size_i, req_addr_i[1:0])
                | ({2'b00, req_addr_i[31:2]} >= MEM_WORDS);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        addr_lo_d   = addr_lo_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_mask_d  = 4'b0000;
        mem_data_d  = mem_data_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d        = req_we_i;
                    size_d      = req_size_i;
                    uns_d       = req_unsigned_i;
                    addr_lo_d   = req_addr_i[1:0];
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    if (req_bad) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        state_d     = RESP;
                    end else begin
                        mem_addr_d = {2'b00, req_addr_i[31:2]};
                        if (req_we_i) begin
                            mem_we_d   = 1'b1;
                            mem_mask_d = al_mask;
                            mem_data_d = al_wdata;
                        end
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (we_q) begin
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                rsp_rdata_d = al_rdata;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            addr_lo_q   <= 2'b00;
            mem_addr_q  <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_mask_q  <= 4'b0000;
            mem_data_q  <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            addr_lo_q   <= addr_lo_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_mask_q  <= mem_mask_d;
            mem_data_q  <= mem_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o   = idle;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_we_o      = mem_we_q;
    assign mem_wr_mask_o = mem_mask_q;
    assign mem_data_o    = mem_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu with a behavioural byte-masked memory.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_wr_mask_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    int n_checks = 0;
    int n_errors = 0;
    int we_count = 0;
    logic [32:0] sb_q[$];
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    mem_lsu #(.MEM_WORDS(1024)) dut (
        .clk            (clk),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_wr_mask_o  (mem_wr_mask_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i)
    );

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem_data_i = 32'h0;
    end

    // Downstream memory: masked write, registered read.
    always @(posedge clk) begin
        if (mem_we_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_wr_mask_o[b]) mem[mem_addr_o[9:0]][8*b +: 8] <= mem_data_o[8*b +: 8];
        end
        mem_data_i <= mem[mem_addr_o[9:0]];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Count write-enable cycles; pop and compare every response handshake.
    always @(negedge clk) begin
        if (mem_we_o) we_count++;
        if (rsp_valid_o && rsp_ready_i && !reset_i) begin
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                logic [32:0] e;
                e = sb_q.pop_front();
                check_eq("rsp_err", {31'h0, rsp_err_o}, {31'h0, e[32]});
                check_eq("rsp_rdata", rsp_rdata_o, e[31:0]);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("req_ready_wait", {31'h0, req_ready_o}, 32'd1);
    endtask

    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input logic [3:0] exp_mask, input logic [31:0] exp_mdata);
        int lat;
        int exp_lat;
        int we_before;
        exp_lat = exp_err ? 1 : (we ? 2 : 3);
        wait_ready();
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        sb_q.push_back({exp_err, exp_rdata});
        we_before = we_count;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        check_eq("mem_we_t1", {31'h0, mem_we_o}, {31'h0, (!exp_err && we)});
        if (!exp_err) check_eq("mem_addr_t1", mem_addr_o, {2'b00, addr[31:2]});
        if (!exp_err && we) begin
            check_eq("mem_mask_t1", {28'h0, mem_wr_mask_o}, {28'h0, exp_mask});
            check_eq("mem_data_t1", mem_data_o, exp_mdata);
        end
        lat = 1;
        while (!rsp_valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq("rsp_latency", lat, exp_lat);
        if (exp_err) check_eq("err_no_write", we_count, we_before);
    endtask

    initial begin
        logic [31:0] held;
        reset_i        = 1'b1;
        req_valid_i    = 1'b0;
        req_we_i       = 1'b0;
        req_size_i     = 2'd0;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h0;
        req_wdata_i    = 32'h0;
        rsp_ready_i    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", {31'h0, req_ready_o}, 32'd1);
        check_eq("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'd0);
        check_eq("rst_rsp_err", {31'h0, rsp_err_o}, 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        check_eq("rst_mem_we", {31'h0, mem_we_o}, 32'd0);
        check_eq("rst_mem_mask", {28'h0, mem_wr_mask_o}, 32'd0);
        check_eq("rst_mem_addr", mem_addr_o, 32'd0);
        check_eq("rst_mem_data", mem_data_o, 32'd0);
        reset_i = 1'b0;

        // Stores
        send(1'b1, 2'd0, 1'b0, 32'h0000_0006, 32'h0000_00A5, 1'b0, 32'h0, 4'b0100, 32'hA5A5_A5A5);
        send(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h8081_7F01, 1'b0, 32'h0, 4'b1111, 32'h8081_7F01);
        send(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h1234_BEEF, 1'b0, 32'h0, 4'b1100, 32'hBEEF_BEEF);
        send(1'b1, 2'd0, 1'b0, 32'h0000_0021, 32'hFFFF_FF3C, 1'b0, 32'h0, 4'b0010, 32'h3C3C_3C3C);

        // Loads with extension
        send(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, 1'b0, 32'hFFFF_FF80, 4'b0, 32'h0);
        send(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0, 1'b0, 32'h0000_8081, 4'b0, 32'h0);
        send(1'b0, 2'd1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h0000_7F01, 4'b0, 32'h0);
        send(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 1'b0, 32'h0000_0080, 4'b0, 32'h0);
        send(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0, 1'b0, 32'hFFFF_8081, 4'b0, 32'h0);
        send(1'b0, 2'd2, 1'b1, 32'h0000_0010, 32'h0, 1'b0, 32'h8081_7F01, 4'b0, 32'h0);
        send(1'b0, 2'd0, 1'b0, 32'h0000_0006, 32'h0, 1'b0, 32'hFFFF_FFA5, 4'b0, 32'h0);
        send(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'h00A5_0000, 4'b0, 32'h0);
        send(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'hBEEF_3C00, 4'b0, 32'h0);
        send(1'b0, 2'd0, 1'b0, 32'h0000_0021, 32'h0, 1'b0, 32'h0000_003C, 4'b0, 32'h0);

        // Rejected requests
        send(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
        send(1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
        send(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 1'b1, 32'h0, 4'b0, 32'h0);
        send(1'b1, 2'd3, 1'b0, 32'h0000_0008, 32'h1111_1111, 1'b1, 32'h0, 4'b0, 32'h0);
        send(1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 32'h0, 4'b0, 32'h0);
        send(1'b1, 2'd1, 1'b0, 32'h0000_0013, 32'hDEAD_BEEF, 1'b1, 32'h0, 4'b0, 32'h0);

        // Last word in range
        send(1'b1, 2'd2, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 4'b1111, 32'hCAFE_F00D);
        send(1'b0, 2'd2, 1'b0, 32'h0000_0FFC, 32'h0, 1'b0, 32'hCAFE_F00D, 4'b0, 32'h0);

        // Backpressure: response must hold for 5 cycles
        wait_ready();
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        send(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, 1'b0, 32'hFFFF_FF80, 4'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("stall_valid", {31'h0, rsp_valid_o}, 32'd1);
            check_eq("stall_rdata", rsp_rdata_o, 32'hFFFF_FF80);
            check_eq("stall_req_ready", {31'h0, req_ready_o}, 32'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check_eq("release_valid", {31'h0, rsp_valid_o}, 32'd0);
        check_eq("release_req_ready", {31'h0, req_ready_o}, 32'd1);
        send(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0, 1'b0, 32'h0000_8081, 4'b0, 32'h0);

        // Reset during WAIT drops the load
        wait_ready();
        req_valid_i    = 1'b1;
        req_we_i       = 1'b0;
        req_size_i     = 2'd2;
        req_unsigned_i = 1'b0;
        req_addr_i     = 32'h0000_0010;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        check_eq("rstw_req_ready", {31'h0, req_ready_o}, 32'd1);
        check_eq("rstw_rsp_valid", {31'h0, rsp_valid_o}, 32'd0);
        check_eq("rstw_mem_we", {31'h0, mem_we_o}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check_eq("rstw_no_rsp", {31'h0, rsp_valid_o}, 32'd0);
        end
        send(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'h8081_7F01, 4'b0, 32'h0);

        repeat (4) @(posedge clk);
        check_eq("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
